dual_port_ram_clr: RTL and testbench



---
 rtl/dual_port_ram_clr.sv | 116 +++++++++++
 tb/tb_dual_port_ram_clr.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_clr.sv
// Parametrised true dual-port RAM with post-reset clear sequencer, collision flag
// and optional output register stage (enabled by defining DPRAM_OUT_REG_EN).
module dual_port_ram_clr #(
  parameter int unsigned             DATA_WIDTH  = 8,
  parameter int unsigned             ADDR_WIDTH  = 6,
  parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  busy,
  output logic                  collision
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_a_q, rd_b_q;
  logic                    coll_q;
  logic                    ready, acc_a, acc_b, wr_a, wr_b, coll_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready  = (state_q == READY);
  assign acc_a  = ready & en_a;
  assign acc_b  = ready & en_b;
  assign wr_a   = acc_a & we_a;
  assign wr_b   = acc_b & we_b;
  assign coll_d = acc_a & acc_b & (addr_a == addr_b) & (we_a | we_b);

  // Port A write is issued last so it wins a same-address write/write conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[cnt_q] <= CLEAR_VALUE;
      end else begin
        if (wr_b) mem[addr_b] <= data_b;
        if (wr_a) mem[addr_a] <= data_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
      coll_q <= 1'b0;
    end else begin
      if (acc_a) rd_a_q <= mem[addr_a];
      if (acc_b) rd_b_q <= mem[addr_b];
      coll_q <= coll_d;
    end
  end

  assign busy = (state_q == CLEAR);

`ifdef DPRAM_OUT_REG_EN
  logic                  en_a_q, en_b_q, coll_o_q;
  logic [DATA_WIDTH-1:0] q_a_q, q_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_a_q   <= 1'b0;
      en_b_q   <= 1'b0;
      q_a_q    <= '0;
      q_b_q    <= '0;
      coll_o_q <= 1'b0;
    end else begin
      en_a_q   <= acc_a;
      en_b_q   <= acc_b;
      if (en_a_q) q_a_q <= rd_a_q;
      if (en_b_q) q_b_q <= rd_b_q;
      coll_o_q <= coll_q;
    end
  end

  assign q_a       = q_a_q;
  assign q_b       = q_b_q;
  assign collision = coll_o_q;
`else
  assign q_a       = rd_a_q;
  assign q_b       = rd_b_q;
  assign collision = coll_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Scoreboard bench for dual_port_ram_clr: array reference model, queued expectations,
// independent negedge monitor. Honours DPRAM_OUT_REG_EN for the read latency.
module tb_dual_port_ram_clr;

`ifdef DPRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [5:0] addr_a = '0, addr_b = '0;
  logic [7:0] data_a = '0, data_b = '0;
  logic [7:0] q_a, q_b;
  logic       busy, collision;

  dual_port_ram_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .CLEAR_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b),
    .busy(busy), .collision(collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int         due;
    logic [7:0] qa;
    logic [7:0] qb;
    logic       coll;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [64];
  logic [7:0] qa_m, qb_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].due < cyc) begin
        chk("sb_overdue", 32'(sb[0].due), 32'(cyc));
        void'(sb.pop_front());
      end else if (sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("q_a", 32'(q_a), 32'(e.qa));
        chk("q_b", 32'(q_b), 32'(e.qb));
        chk("collision", 32'(collision), 32'(e.coll));
      end
    end
  end

  // One READY-state access on both ports; the model applies the access rules directly.
  task automatic op(input bit ea, input bit wa, input logic [5:0] aa, input logic [7:0] da,
                    input bit eb, input bit wb, input logic [5:0] ab, input logic [7:0] db);
    exp_t e;
    en_a = ea; we_a = wa; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; addr_b = ab; data_b = db;
    if (ea) qa_m = mem_m[aa];
    if (eb) qb_m = mem_m[ab];
    if (eb && wb) mem_m[ab] = db;
    if (ea && wa) mem_m[aa] = da;
    e.due  = cyc + LAT;
    e.qa   = qa_m;
    e.qb   = qb_m;
    e.coll = ea && eb && (aa == ab) && (wa || wb);
    sb.push_back(e);
    tick();
  endtask

  task automatic drain();
    int k = 0;
    en_a = 0; en_b = 0; we_a = 0; we_b = 0;
    while (sb.size() > 0 && k < 10) begin
      tick();
      k++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      tick();
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_q_a", 32'(q_a), 32'd0);
      chk("rst_q_b", 32'(q_b), 32'd0);
      chk("rst_coll", 32'(collision), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
    qa_m = 8'h00;
    qb_m = 8'h00;
  endtask

  // Port traffic is driven throughout the clear and must have no visible effect.
  task automatic run_clear(input int abort_at);
    int n = 0;
    bit zero_ok = 1'b1;
    en_a = 1; we_a = 1; addr_a = 6'h07; data_a = 8'h66;
    en_b = 1; we_b = 1; addr_b = 6'h07; data_b = 8'h11;
    do begin
      tick();
      n++;
      if (q_a !== 8'h00 || q_b !== 8'h00 || collision !== 1'b0) zero_ok = 1'b0;
      if (abort_at > 0 && n == abort_at) begin
        chk("busy_mid_clear", 32'(busy), 32'd1);
        do_reset(1);
        n = 0;
        abort_at = 0;
      end
    end while (busy === 1'b1 && n < 200);
    chk("clear_length", 32'(n), 32'd64);
    chk("q_zero_during_clear", 32'(zero_ok), 32'd1);
    en_a = 0; en_b = 0; we_a = 0; we_b = 0;
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      logic [5:0] aa, ab;
      aa = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      ab = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      op(1'($urandom_range(0, 3) != 0), 1'($urandom), aa, 8'($urandom),
         1'($urandom_range(0, 3) != 0), 1'($urandom), ab, 8'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    do_reset(2);
    run_clear(0);

    op(1, 0, 6'h3F, 8'h00, 1, 0, 6'h00, 8'h00);
    op(1, 0, 6'h07, 8'h00, 1, 0, 6'h07, 8'h00);
    op(1, 1, 6'h01, 8'h33, 1, 1, 6'h02, 8'h44);
    op(1, 0, 6'h02, 8'h00, 1, 0, 6'h01, 8'h00);
    op(1, 1, 6'h03, 8'h55, 0, 0, 6'h00, 8'h00);
    op(1, 1, 6'h03, 8'h72, 0, 0, 6'h00, 8'h00);
    op(1, 0, 6'h03, 8'h00, 0, 1, 6'h03, 8'hEE);
    op(1, 1, 6'h05, 8'h63, 1, 1, 6'h05, 8'h24);
    op(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00);
    op(1, 0, 6'h05, 8'h00, 1, 0, 6'h05, 8'h00);
    op(1, 0, 6'h09, 8'h00, 1, 1, 6'h09, 8'hA5);
    op(1, 0, 6'h09, 8'h00, 1, 0, 6'h09, 8'h00);
    op(0, 1, 6'h0A, 8'h99, 0, 1, 6'h0A, 8'h98);
    op(1, 0, 6'h0A, 8'h00, 0, 0, 6'h00, 8'h00);
    rand_ops(400);
    drain();

    do_reset(2);
    run_clear(20);
    op(1, 0, 6'h05, 8'h00, 1, 0, 6'h3F, 8'h00);
    op(1, 1, 6'h01, 8'h33, 1, 1, 6'h02, 8'h44);
    op(1, 0, 6'h02, 8'h00, 1, 0, 6'h01, 8'h00);
    rand_ops(300);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
